// File: rtl/multi_lane_write_buffer.sv
// Parallel-to-serial output buffer: shifts an aligned word onto 1..LANES data lanes,
// one beat per write_sig strobe. Optional holding register (MLWB_DOUBLE_BUF_EN) lets a
// second word queue up during SHIFT so back-to-back frames go out with no idle beat.
module multi_lane_write_buffer #(
  parameter int unsigned BUF_SIZE  = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          write_sig,
  input  logic [BUF_SIZE-1:0]           data_in,
  input  logic [$clog2(BUF_SIZE+1)-1:0] write_count,
  output logic [LANES-1:0]              data_out,
  output logic                          busy,
  output logic                          ready,
  output logic                          done_sig
);

  localparam int unsigned CW = $clog2(BUF_SIZE + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [BUF_SIZE-1:0] sreg_q, sreg_d;
  logic [CW-1:0]       beats_q, beats_d;
  logic                done_q, done_d;
  logic [CW-1:0]       cnt_in;
  logic [BUF_SIZE-1:0] word_in;
  logic [CW-1:0]       beats_in;
  logic                last_beat;

`ifdef MLWB_DOUBLE_BUF_EN
  logic                hold_full_q, hold_full_d;
  logic [BUF_SIZE-1:0] hold_data_q, hold_data_d;
  logic [CW-1:0]       hold_beats_q, hold_beats_d;
`endif

  // Keep only the valid bits at the aligned end so a partial last beat shifts out zeros.
  function automatic logic [BUF_SIZE-1:0] align_word(input logic [BUF_SIZE-1:0] d,
                                                    input logic [CW-1:0]       c);
    logic [BUF_SIZE-1:0] w;
    w = '0;
    for (int i = 0; i < int'(BUF_SIZE); i++) begin
      if (LSB_FIRST) begin
        if (i < int'(c)) w[i] = d[i];
      end else begin
        if (i >= int'(BUF_SIZE) - int'(c)) w[i] = d[i];
      end
    end
    return w;
  endfunction

  // Decode the incoming request: clamp the count, align the word, round beats up.
  always_comb begin
    cnt_in   = (write_count > CW'(BUF_SIZE)) ? CW'(BUF_SIZE) : write_count;
    word_in  = align_word(data_in, cnt_in);
    beats_in = CW'((int'(cnt_in) + int'(LANES) - 1) / int'(LANES));
  end

  // A zero-beat word (only reachable via handoff) completes without needing a strobe.
  assign last_beat = (beats_q == '0) || (write_sig && (beats_q == CW'(1)));

  // Next-state logic: load, shift, completion and holding-register handoff.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    beats_d = beats_q;
    done_d  = 1'b0;
`ifdef MLWB_DOUBLE_BUF_EN
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_beats_d = hold_beats_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cnt_in == '0) begin
            done_d = 1'b1;
          end else begin
            sreg_d  = word_in;
            beats_d = beats_in;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (write_sig && (beats_q != '0)) begin
          sreg_d  = LSB_FIRST ? (sreg_q >> LANES) : (sreg_q << LANES);
          beats_d = beats_q - CW'(1);
        end
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef MLWB_DOUBLE_BUF_EN
          if (hold_full_q) begin
            sreg_d      = hold_data_q;
            beats_d     = hold_beats_q;
            hold_full_d = 1'b0;
            state_d     = StShift;
          end else if (start) begin
            sreg_d  = word_in;
            beats_d = beats_in;
            state_d = StShift;
          end
`endif
        end
`ifdef MLWB_DOUBLE_BUF_EN
        else if (start && !hold_full_q) begin
          hold_full_d  = 1'b1;
          hold_data_d  = word_in;
          hold_beats_d = beats_in;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards both the active and the held word.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
`ifdef MLWB_DOUBLE_BUF_EN
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_beats_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beats_q <= beats_d;
      done_q  <= done_d;
`ifdef MLWB_DOUBLE_BUF_EN
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_beats_q <= hold_beats_d;
`endif
    end
  end

  // Present the current beat; lane LANES-1 carries the earliest bit.
  always_comb begin
    data_out = '0;
    if (state_q == StShift) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (LSB_FIRST) data_out[int'(LANES) - 1 - i] = sreg_q[i];
        else           data_out[i] = sreg_q[int'(BUF_SIZE) - int'(LANES) + i];
      end
    end
  end

  assign busy     = (state_q == StShift);
  assign done_sig = done_q;
`ifdef MLWB_DOUBLE_BUF_EN
  assign ready = !hold_full_q;
`else
  assign ready = !busy;
`endif

endmodule

// File: tb/tb_multi_lane_write_buffer.sv
// Directed bench for multi_lane_write_buffer: three instances (1 lane MSB-first,
// 2 lanes MSB-first, 4 lanes LSB-first) share data/strobe inputs but have separate starts.
// The holding-register scenario is compiled in when MLWB_DOUBLE_BUF_EN is defined.
module tb_multi_lane_write_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic       write_sig = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] write_count = '0;
  logic [0:0] d1;
  logic [1:0] d2;
  logic [3:0] d4;
  logic [2:0] busy_v, ready_v, done_v;

  int         sel = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] dout_s;
  logic       busy_s, ready_s, done_s;

  always #5 clk = ~clk;

  multi_lane_write_buffer #(.BUF_SIZE(8), .LANES(1), .LSB_FIRST(1'b0)) u1 (
    .sys_clk(clk), .rst_n(rst_n), .start(start_v[0]), .write_sig(write_sig),
    .data_in(data_in), .write_count(write_count), .data_out(d1),
    .busy(busy_v[0]), .ready(ready_v[0]), .done_sig(done_v[0]));

  multi_lane_write_buffer #(.BUF_SIZE(8), .LANES(2), .LSB_FIRST(1'b0)) u2 (
    .sys_clk(clk), .rst_n(rst_n), .start(start_v[1]), .write_sig(write_sig),
    .data_in(data_in), .write_count(write_count), .data_out(d2),
    .busy(busy_v[1]), .ready(ready_v[1]), .done_sig(done_v[1]));

  multi_lane_write_buffer #(.BUF_SIZE(8), .LANES(4), .LSB_FIRST(1'b1)) u4 (
    .sys_clk(clk), .rst_n(rst_n), .start(start_v[2]), .write_sig(write_sig),
    .data_in(data_in), .write_count(write_count), .data_out(d4),
    .busy(busy_v[2]), .ready(ready_v[2]), .done_sig(done_v[2]));

  // Route the selected instance to a common set of observation signals.
  always_comb begin
    dout_s = 4'(d1);
    if (sel == 1) dout_s = 4'(d2);
    if (sel == 2) dout_s = d4;
    busy_s  = busy_v[sel];
    ready_s = ready_v[sel];
    done_s  = done_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue one word on instance s and strobe it out; exp holds beat j in nibble j.
  task automatic run_word(input int s, input logic [7:0] d, input logic [3:0] c,
                          input int nb, input logic [31:0] exp, input logic ws0,
                          input string tag);
    sel         = s;
    data_in     = d;
    write_count = c;
    start_v[s]  = 1'b1;
    write_sig   = ws0;
    step();
    start_v   = '0;
    write_sig = 1'b0;
    check({tag, "_busy"}, 32'(busy_s), 32'd1);
    for (int j = 0; j < nb; j++) begin
      check($sformatf("%s_beat%0d", tag, j), 32'(dout_s), 32'(exp[4*j +: 4]));
      step();
      check($sformatf("%s_hold%0d", tag, j), 32'(dout_s), 32'(exp[4*j +: 4]));
      write_sig = 1'b1;
      step();
      write_sig = 1'b0;
      check($sformatf("%s_done%0d", tag, j), 32'(done_s), (j == nb - 1) ? 32'd1 : 32'd0);
    end
    check({tag, "_idle"}, 32'(busy_s), 32'd0);
    check({tag, "_zero"}, 32'(dout_s), 32'd0);
    step();
    check({tag, "_donefall"}, 32'(done_s), 32'd0);
  endtask

  initial begin
    // Reset values on every instance
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check($sformatf("rst%0d_dout", s), 32'(dout_s), 32'd0);
      check($sformatf("rst%0d_busy", s), 32'(busy_s), 32'd0);
      check($sformatf("rst%0d_ready", s), 32'(ready_s), 32'd1);
      check($sformatf("rst%0d_done", s), 32'(done_s), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // 1 lane MSB first: 9C -> 1,0,0,1,1,1,0,0
    run_word(0, 8'h9C, 4'd8, 8, 32'h0011_1001, 1'b0, "msb9c");

    // Reset in the middle of F0/6 after three strobes
    sel         = 0;
    data_in     = 8'hF0;
    write_count = 4'd6;
    start_v[0]  = 1'b1;
    step();
    start_v = '0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("f0_beat%0d", j), 32'(dout_s), 32'd1);
      write_sig = 1'b1;
      step();
      write_sig = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout_s), 32'd0);
    check("midrst_busy", 32'(busy_s), 32'd0);
    check("midrst_ready", 32'(ready_s), 32'd1);
    check("midrst_done", 32'(done_s), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("postrst_done", 32'(done_s), 32'd0);
    run_word(0, 8'h50, 4'd4, 4, 32'h0000_1010, 1'b0, "msb50");

    // 4 lanes LSB first: A5 -> pins A then 5; write_sig alongside start is ignored
    run_word(2, 8'hA5, 4'd8, 2, 32'h0000_005A, 1'b1, "lsba5");

    // 2 lanes MSB first, partial last beat: 10110 -> 10, 11, 00
    run_word(1, 8'b1011_0000, 4'd5, 3, 32'h0000_0032, 1'b0, "l2p5");

    // Zero-length word: done the cycle after start, never busy
    sel         = 0;
    data_in     = 8'hFF;
    write_count = 4'd0;
    start_v[0]  = 1'b1;
    step();
    start_v = '0;
    check("cnt0_done", 32'(done_s), 32'd1);
    check("cnt0_busy", 32'(busy_s), 32'd0);
    check("cnt0_dout", 32'(dout_s), 32'd0);
    step();
    check("cnt0_donefall", 32'(done_s), 32'd0);

    // Count 12 clamps to 8 beats: A5 -> 1,0,1,0,0,1,0,1
    run_word(0, 8'hA5, 4'd12, 8, 32'h1010_0101, 1'b0, "clamp");

    // write_sig while idle does nothing
    sel       = 0;
    write_sig = 1'b1;
    step();
    write_sig = 1'b0;
    check("idlews_dout", 32'(dout_s), 32'd0);
    check("idlews_busy", 32'(busy_s), 32'd0);
    check("idlews_done", 32'(done_s), 32'd0);

`ifdef MLWB_DOUBLE_BUF_EN
    // Back-to-back FF then 00 through the holding register; third start is dropped
    sel         = 0;
    data_in     = 8'hFF;
    write_count = 4'd8;
    start_v[0]  = 1'b1;
    step();
    check("db_ready1", 32'(ready_s), 32'd1);
    data_in = 8'h00;
    step();
    check("db_ready0", 32'(ready_s), 32'd0);
    data_in = 8'h0F;
    step();
    start_v = '0;
    check("db_ready0b", 32'(ready_s), 32'd0);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("db_beat%0d", j), 32'(dout_s), (j < 8) ? 32'd1 : 32'd0);
      check($sformatf("db_busy%0d", j), 32'(busy_s), 32'd1);
      write_sig = 1'b1;
      step();
      write_sig = 1'b0;
      check($sformatf("db_done%0d", j), 32'(done_s), (j == 7 || j == 15) ? 32'd1 : 32'd0);
      if (j == 7) check("db_handoff_ready", 32'(ready_s), 32'd1);
    end
    check("db_end_busy", 32'(busy_s), 32'd0);
    step();
    check("db_end_idle", 32'(busy_s), 32'd0);
    check("db_end_done", 32'(done_s), 32'd0);
`else
    // Without the holding register a start during SHIFT is dropped
    sel         = 0;
    data_in     = 8'hFF;
    write_count = 4'd2;
    start_v[0]  = 1'b1;
    step();
    data_in     = 8'h00;
    write_count = 4'd8;
    check("sb_ready0", 32'(ready_s), 32'd0);
    step();
    start_v = '0;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("sb_beat%0d", j), 32'(dout_s), 32'd1);
      write_sig = 1'b1;
      step();
      write_sig = 1'b0;
    end
    check("sb_done", 32'(done_s), 32'd1);
    check("sb_busy", 32'(busy_s), 32'd0);
    step();
    check("sb_stay_idle", 32'(busy_s), 32'd0);
    check("sb_ready1", 32'(ready_s), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_lane_write_buffer.md
# multi_lane_write_buffer

- Parallel-to-serial output buffer.
- Shifts a left- or right-aligned word onto 1..N data lanes, advancing one beat per synchronous `write_sig` strobe.
- Sits between protocol controllers and the output pins of the MITM datapath, driven by an `EdgeDetector` on the bus clock.
- Successor of the single-lane serial write buffer: adds lane width, selectable bit order, and an optional holding register for gap-free back-to-back frames.

## Interface

Parameters:

- `BUF_SIZE`, 8: word width in bits; must be a multiple of `LANES`.
- `LANES`, 1: bits emitted per beat (1, 2 or 4).
- `LSB_FIRST`, 0: 0 = MSB first, word left-aligned in `data_in`; 1 = LSB first, word right-aligned.

Ports (clock and reset first):

- `sys_clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle request to queue `data_in`/`write_count`.
- `write_sig` input 1: one-cycle strobe; advances one beat.
- `data_in` input `BUF_SIZE`: word to send.
- `write_count` input `$clog2(BUF_SIZE+1)`: number of valid bits.
- `data_out` output `LANES`: current beat; lane `LANES-1` carries the earliest bit of the beat.
- `busy` output 1: a word is being shifted.
- `ready` output 1: `start` will be accepted this cycle.
- `done_sig` output 1: one-cycle pulse when a word completes.

## Operation

- Reset values: `data_out`=0, `busy`=0, `ready`=1, `done_sig`=0. Shift register, holding register and counters are cleared.
- States:
  - IDLE: `busy`=0. An accepted `start` loads the shift register and goes to SHIFT.
  - SHIFT: `busy`=1. Each `write_sig` advances one beat. After the final beat's `write_sig`, `done_sig` pulses. The block then goes to IDLE, or stays in SHIFT if a held word exists (see Configuration).
- Beats per word = ceil(`write_count`/`LANES`). Bits come from the aligned end of `data_in`; unused lanes in a partial last beat drive 0.
- `write_count` > `BUF_SIZE` is clamped to `BUF_SIZE`.
- `write_count`=0 is accepted. `done_sig` pulses the next cycle, `data_out` stays 0, and the block returns to IDLE.
- `start` while `ready`=0 is ignored with no side effects.
- `data_out` is 0 whenever no word is active.
- `rst_n` low mid-word: both the active and the held word are discarded, no `done_sig`, and outputs return to reset values asynchronously.

## Timing

- `start` sampled at edge k (IDLE): first beat on `data_out` and `busy`=1 from edge k+1.
- A `write_sig` sampled at edge k shifts; the next beat is visible from k+1.
- Last beat's `write_sig` at edge k: `done_sig`=1 for exactly the cycle after edge k+1. Without a held word, `data_out`=0 and `busy`=0 from k+1.
- `start` and `write_sig` in the same cycle while IDLE: load only; `write_sig` is ignored.
- `start` and `write_sig` in the same cycle while SHIFT (with the holding register): both take effect.
- `write_sig` while IDLE: ignored.
- The source must present the bit for the next rising bus edge, so `write_sig` comes from the falling bus edge. Bus clock period must be ≥ 4 `sys_clk` cycles.

## Configuration

- Macro: `MLWB_DOUBLE_BUF_EN`.
- Defined:
  - One holding register is added; `ready` = !holding_full.
  - `start` during SHIFT captures `data_in`/`write_count` into the holding register.
  - When the active word's last `write_sig` is sampled at edge k, the held word loads at k+1 and its first beat appears on `data_out`. `busy` stays 1, `done_sig` still pulses for the finished word, and the holding register empties.
  - Gap between words is zero bus beats.
- Undefined:
  - No holding register; `ready` = !`busy`.
  - A `start` during SHIFT is ignored.

## Test plan

- `LANES`=1, MSB first, `data_in`=8'h9C, count 8, 8 `write_sig` strobes: `data_out` sequence 1,0,0,1,1,1,0,0; a single `done_sig` after the 8th strobe; then `busy`=0, `data_out`=0.
- `LANES`=1, `data_in`=8'hF0, count 6, `rst_n` low after 3 strobes: outputs at reset values, no `done_sig`. A following start with `data_in`=8'h50, count 4 gives 0,1,0,1 and `done_sig`.
- `LANES`=4, `LSB_FIRST`=1, `data_in`=8'hA5, count 8: `data_out` beats 4'h5 then 4'hA (lane 3 carries bit 0, so 4'h5 bit-reversed reads 4'hA on the pins); `done_sig` after the 2nd strobe.
- `LANES`=2, count 5, `data_in`=8'b10110_000: beats 2'b10, 2'b11, 2'b00 (partial last beat, lane 0 = 0); 3 strobes then `done_sig`.
- `MLWB_DOUBLE_BUF_EN` on, `LANES`=1: start 8'hFF (count 8), then start 8'h00 (count 8) during SHIFT. `ready`=0 until handoff; 16 strobes produce eight 1s then eight 0s with no idle beat and two `done_sig` pulses. A third start while `ready`=0 is ignored.
- Edge cases: count 0 gives `done_sig` the cycle after start with `data_out`=0; count 12 with `BUF_SIZE`=8 is clamped to 8 beats; `write_sig` in IDLE causes no output change.
